// File: rtl/lsu_pkg.sv
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared types and constants for the load/store unit: FSM state
//            encoding, funct3 access-size codes, byte-enable width and a
//            helper that derives byte enables from size and address offset.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned BE_W = 4;

  // funct3[1:0] encodes the access size for both signed and unsigned loads.
  function automatic logic [BE_W-1:0] byte_enables(input logic [2:0] f3,
                                                   input logic [1:0] off);
    logic [BE_W-1:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_load_align.sv
// ============================================================================
// Module   : lsu_load_align
// Purpose  : Combinational load alignment: selects the addressed byte/half
//            lane of the bus read word and sign- or zero-extends it.
// Ports    : rdata_i     - raw bus read word
//            off_i       - byte offset within the word (addr[1:0])
//            funct3_i    - load size/sign code
//            load_data_o - extended result
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      off_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] load_data_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rdata_i[{off_i, 3'b000} +: 8];
    // A legal half access only ever sits at offset 0 or 2.
    w_half = rdata_i[{off_i[1], 4'b0000} +: 16];
    case (funct3_i)
      F3_B:    load_data_o = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_BU:   load_data_o = {{(XLEN-8){1'b0}}, w_byte};
      F3_H:    load_data_o = {{(XLEN-16){w_half[15]}}, w_half};
      F3_HU:   load_data_o = {{(XLEN-16){1'b0}}, w_half};
      default: load_data_o = rdata_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module   : load_store_unit
// Purpose  : Memory-access stage of the single-cycle RISC-V core. Runs one
//            req/gnt/rvalid data-bus transaction per load/store, stalls the
//            core while it is outstanding and returns extended load data.
// Ports    : clk_i, rst_ni          - clock, async active-low reset
//            mem_read_i/mem_write_i - instruction is a load / store
//            funct3_i, addr_i       - access size/sign, effective address
//            wdata_i                - rs2 store data
//            lsu_stall_o            - hold PC and register-file write
//            load_data_o/valid_o    - extended load result and its strobe
//            misaligned_o, lsu_err_o- fault flags, valid in DONE only
//            dbus_*                 - data-bus request/response channel
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [2:0]        funct3_i,
  input  logic [XLEN-1:0]   addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic              lsu_stall_o,
  output logic [XLEN-1:0]   load_data_o,
  output logic              load_valid_o,
  output logic              misaligned_o,
  output logic              lsu_err_o,
  output logic              dbus_req_o,
  output logic              dbus_we_o,
  output logic [XLEN-1:0]   dbus_addr_o,
  output logic [BE_W-1:0]   dbus_be_o,
  output logic [XLEN-1:0]   dbus_wdata_o,
  input  logic              dbus_gnt_i,
  input  logic              dbus_rvalid_i,
  input  logic [XLEN-1:0]   dbus_rdata_i,
  input  logic              dbus_err_i
);

  // Counter must hold TIMEOUT_CYCLES without wrapping.
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e        state_q, state_d;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [2:0]        funct3_q;
  logic              we_q;
  logic              mis_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   load_data_q;

  logic              w_memop;
  logic              w_illegal;
  logic              w_misaligned;
  logic              w_timeout;
  logic              w_in_req;
  logic              w_in_done;
  logic [XLEN-1:0]   w_store;
  logic [XLEN-1:0]   w_aligned;

  assign w_memop = mem_read_i | mem_write_i;

  // Counter value TO_LAST marks the last allowed bus cycle of an access.
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (cnt_q >= TO_LAST);

  // Decode of the incoming instruction, used only in IDLE.
  always_comb begin
    w_illegal = 1'b0;
    if (mem_read_i && mem_write_i) begin
      w_illegal = 1'b1;
    end else if (mem_read_i) begin
      w_illegal = (funct3_i == 3'b011) || (funct3_i == 3'b110) ||
                  (funct3_i == 3'b111);
    end else if (mem_write_i) begin
      w_illegal = !((funct3_i == F3_B) || (funct3_i == F3_H) ||
                    (funct3_i == F3_W));
    end

    case (funct3_i[1:0])
      2'b01:   w_misaligned = addr_i[0];
      2'b10:   w_misaligned = |addr_i[1:0];
      default: w_misaligned = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state. A grant in the last allowed cycle wins over the timeout
  // so an accepted request is always followed by its response wait.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (w_memop) begin
          state_d = (w_illegal || w_misaligned) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (dbus_gnt_i) begin
          state_d = S_WAIT;
        end else if (w_timeout) begin
          state_d = S_DONE;
        end
      end
      S_WAIT: begin
        if (dbus_rvalid_i || w_timeout) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Transaction context, fault flags, timeout counter and load result
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      funct3_q    <= '0;
      we_q        <= 1'b0;
      mis_q       <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      load_data_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_memop) begin
            addr_q   <= addr_i;
            wdata_q  <= wdata_i;
            funct3_q <= funct3_i;
            we_q     <= mem_write_i;
            mis_q    <= !w_illegal && w_misaligned;
            err_q    <= w_illegal;
            cnt_q    <= '0;
          end
        end
        S_REQ: begin
          cnt_q <= cnt_q + 1'b1;
          if (!dbus_gnt_i && w_timeout) begin
            err_q <= 1'b1;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (dbus_rvalid_i) begin
            err_q <= dbus_err_i;
            if (!we_q && !dbus_err_i) begin
              load_data_q <= w_aligned;
            end
          end else if (w_timeout) begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  lsu_load_align #(
    .XLEN (XLEN)
  ) u_load_align (
    .rdata_i     (dbus_rdata_i),
    .off_i       (addr_q[1:0]),
    .funct3_i    (funct3_q),
    .load_data_o (w_aligned)
  );

  // Store data replicated across every lane the access could target.
  always_comb begin
    case (funct3_q[1:0])
      2'b00:   w_store = {(XLEN/8){wdata_q[7:0]}};
      2'b01:   w_store = {(XLEN/16){wdata_q[15:0]}};
      default: w_store = wdata_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. Bus fields are driven only in REQ, so everything is zero
  // in reset and an asynchronous reset drops the request at once.
  // --------------------------------------------------------------------------
  always_comb begin
    w_in_req     = (state_q == S_REQ);
    w_in_done    = (state_q == S_DONE);
    lsu_stall_o  = rst_ni & w_memop & !w_in_done;
    dbus_req_o   = w_in_req;
    dbus_we_o    = w_in_req & we_q;
    dbus_addr_o  = w_in_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
    dbus_be_o    = w_in_req ? byte_enables(funct3_q, addr_q[1:0]) : '0;
    dbus_wdata_o = w_in_req ? w_store : '0;
    misaligned_o = w_in_done & mis_q;
    lsu_err_o    = w_in_done & err_q;
    load_valid_o = w_in_done & !we_q & !err_q & !mis_q;
    load_data_o  = load_data_q;
  end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage between the ALU and the writeback select mux of the RISC-V single-cycle core.
- Takes the ALU address, the rs2 store data and funct3, and runs one data-bus transaction with a req/gnt/rvalid handshake.
- Produces sign- or zero-extended load data for the writeback mux.
- Stalls the core while the access is outstanding.

Parameters:
- XLEN, 32, data and address width.
- TIMEOUT_CYCLES, 64, number of bus cycles before the access aborts with an error; 0 disables the timeout.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- mem_read  in  1  current instruction is a load
- mem_write  in  1  current instruction is a store
- funct3  in  3  access size and sign
- addr  in  XLEN  effective address from the ALU
- wdata  in  XLEN  rs2 store data
- lsu_stall  out  1  hold PC and register-file write
- load_data  out  XLEN  extended load result, feeds the writeback mux
- load_valid  out  1  load_data valid this cycle
- misaligned  out  1  access faulted on alignment
- lsu_err  out  1  bus error, timeout or illegal op
- dbus_req  out  1  bus request
- dbus_we  out  1  write enable
- dbus_addr  out  XLEN  word-aligned address (addr[1:0]=0)
- dbus_be  out  4  byte enables
- dbus_wdata  out  XLEN  lane-replicated write data
- dbus_gnt  in  1  request accepted
- dbus_rvalid  in  1  response valid (reads and writes)
- dbus_rdata  in  XLEN  read data
- dbus_err  in  1  error with rvalid

Behaviour:
- Reset: asynchronous, active-low. State goes to IDLE. All outputs are 0 while rst_n is low. Asserting reset mid-transaction drops dbus_req immediately; the bus slave must tolerate this.
- memop = mem_read | mem_write.
- lsu_stall = memop & (state != DONE). This is combinational, so a new memory instruction stalls in the same cycle it appears.
- IDLE:
  - On memop, register addr, wdata, funct3 and op.
  - Aligned legal op: go to REQ.
  - Misaligned op (half with addr[0]=1, word with addr[1:0]!=0): go to DONE with misaligned=1; no bus access.
  - Illegal op (mem_read & mem_write both set; load funct3 of 011/110/111; store funct3 not in 000/001/010): go to DONE with lsu_err=1; no bus access.
- REQ:
  - dbus_req=1. addr/we/be/wdata come from registers and stay stable until gnt.
  - On dbus_gnt, drop req and go to WAIT. Gnt is allowed in the first REQ cycle.
- WAIT:
  - dbus_rvalid is legal no earlier than the cycle after gnt.
  - On rvalid, capture rdata and dbus_err, then go to DONE.
- DONE:
  - Exactly one cycle. lsu_stall=0, so the core retires the instruction at this edge.
  - load_valid=1 only for a load with no error and no misalignment.
  - misaligned and lsu_err are valid only in DONE.
  - Next state is IDLE unconditionally. Back-to-back memory ops therefore each take a fresh IDLE cycle.
- Minimum latency with gnt in the same cycle and rvalid the next cycle: IDLE, REQ, WAIT, DONE = 4 cycles, 3 of them stalled.
- Timeout: a counter is cleared on acceptance and increments in REQ and WAIT. When it reaches TIMEOUT_CYCLES: drop req, set lsu_err, go to DONE. Any late rvalid is ignored once back in IDLE.
- Byte enables, with off = addr[1:0]:
  - SB/LB/LBU: be = 0001 << off
  - SH/LH/LHU: be = 0011 << off
  - SW/LW: be = 1111
- Store data: byte replicated ×4, half replicated ×2, word unchanged.
- Load extension: select the lane by off; LB/LH sign-extend, LBU/LHU zero-extend. load_data is registered and holds its value until the next successful load.
- dbus_err on a store sets lsu_err; memory contents are the slave's concern.

Decomposition:
- Package lsu_pkg holds:
  - state enum {IDLE, REQ, WAIT, DONE}
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101
  - byte-enable width constant 4
- Sub-module lsu_load_align: combinational lane select plus sign/zero extend (rdata, off, funct3 -> load_data).

Test Plan:
- LW at addr 0x1000, gnt in the same cycle, rvalid next cycle with rdata 0xDEADBEEF -> dbus_addr 0x1000, be 1111; load_data 0xDEADBEEF with load_valid in DONE; lsu_stall high 3 cycles.
- LB at 0x1003 with rdata 0x80112233 -> be 1000, load_data 0xFFFFFF80. LBU at the same address -> 0x00000080. LHU at 0x1002 -> 0x00008011.
- SH at 0x2002 with wdata 0x0000ABCD -> dbus_addr 0x2000, be 1100, dbus_wdata 0xABCDABCD, dbus_we 1; no load_valid.
- LW at 0x1002 -> no dbus_req, misaligned=1 in DONE, lsu_stall high 1 cycle. Then a back-to-back SW at 0x3000 completes normally.
- gnt held low -> req held with stable address for 64 cycles, then lsu_err in DONE and req drops.
- rst_n asserted low while in WAIT -> dbus_req, lsu_stall and all outputs 0 with no clock edge. After release, state is IDLE and a subsequent LW completes correctly.
